// File: rtl/dac_update_scheduler.sv
// Paced sample scheduler: register-loaded FIFO of DAC codes, one driver transfer per period tick.
// state       | meaning
// S_IDLE      | scheduler disabled, no transfers issued
// S_WAIT_TICK | enabled, waiting for the next period tick to pop a sample
// S_START     | drv_start asserted for this single cycle
// S_WAIT_DONE | transfer in flight, waiting for drv_done
module dac_update_scheduler #(
    parameter int FIFO_DEPTH  = 16,
    parameter int PERIOD_BITS = 16
) (
    input  logic        bus_clock,
    input  logic        resetn,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [3:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        drv_start,
    output logic [15:0] drv_data,
    input  logic        drv_busy,
    input  logic        drv_done,
    output logic        irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TICK = 2'd1,
        S_START     = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                 state;
    logic                   ctrl_enable;
    logic                   ctrl_irq_en;
    logic                   flush_q;
    logic [PERIOD_BITS-1:0] period_q;
    logic [PERIOD_BITS-1:0] cnt_q;
    logic [15:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          fifo_level;
    logic                   sticky_ovf;
    logic                   sticky_und;
    logic                   sticky_late;

    logic wr_ctrl, wr_period, wr_data, wr_status;
    logic tick, fifo_empty, fifo_full;
    logic push, pop;
    logic set_ovf, set_und, set_late;
    logic fsm_busy;
    logic [7:0]  level_byte;
    logic [31:0] rd_mux;
    logic wdata_unused;

    assign wr_ctrl   = reg_wr && (reg_addr == 4'h0);
    assign wr_period = reg_wr && (reg_addr == 4'h4);
    assign wr_data   = reg_wr && (reg_addr == 4'h8);
    assign wr_status = reg_wr && (reg_addr == 4'hC);

    assign wdata_unused = ^reg_wdata;

    assign tick       = ctrl_enable && (cnt_q == '0);
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
    assign fsm_busy   = (state == S_START) || (state == S_WAIT_DONE);
    assign level_byte = 8'(fifo_level);

    // Full is judged on the level before any same-cycle pop; a flush cycle swallows the write.
    assign push    = wr_data && !flush_q && !fifo_full;
    assign set_ovf = wr_data && !flush_q && fifo_full;

    always_comb begin
        pop      = 1'b0;
        set_und  = 1'b0;
        set_late = 1'b0;
        if (state == S_WAIT_TICK && tick) begin
            if (fifo_empty) begin
                set_und = 1'b1;
            end else if (drv_busy) begin
                set_late = 1'b1;
            end else begin
                pop = 1'b1;
            end
        end
        if (state == S_WAIT_DONE && tick) begin
            set_late = 1'b1;
        end
    end

    always_ff @(posedge bus_clock or negedge resetn) begin
        if (!resetn) begin
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            flush_q     <= 1'b0;
            period_q    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_enable <= reg_wdata[0];
                ctrl_irq_en <= reg_wdata[1];
            end
            flush_q <= wr_ctrl && reg_wdata[2];
            if (wr_period) begin
                period_q <= reg_wdata[PERIOD_BITS-1:0];
            end
        end
    end

    // Holding at PERIOD while disabled doubles as the reload on enable rising.
    always_ff @(posedge bus_clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (!ctrl_enable || tick) begin
            cnt_q <= period_q;
        end else begin
            cnt_q <= cnt_q - PERIOD_BITS'(1);
        end
    end

    always_ff @(posedge bus_clock) begin
        if (push) begin
            mem[wr_ptr] <= reg_wdata[15:0];
        end
    end

    always_ff @(posedge bus_clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush_q) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Set events take priority over write-one-to-clear.
    always_ff @(posedge bus_clock or negedge resetn) begin
        if (!resetn) begin
            sticky_ovf  <= 1'b0;
            sticky_und  <= 1'b0;
            sticky_late <= 1'b0;
            irq         <= 1'b0;
        end else begin
            sticky_ovf  <= set_ovf  || (sticky_ovf  && !(wr_status && reg_wdata[3]));
            sticky_und  <= set_und  || (sticky_und  && !(wr_status && reg_wdata[4]));
            sticky_late <= set_late || (sticky_late && !(wr_status && reg_wdata[5]));
            irq         <= ctrl_irq_en && (sticky_ovf || sticky_und || sticky_late);
        end
    end

    always_ff @(posedge bus_clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            drv_start <= 1'b0;
            drv_data  <= '0;
        end else begin
            drv_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctrl_enable) begin
                        state <= S_WAIT_TICK;
                    end
                end
                S_WAIT_TICK: begin
                    if (!ctrl_enable) begin
                        state <= S_IDLE;
                    end else if (pop) begin
                        drv_data  <= mem[rd_ptr];
                        drv_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (drv_done) begin
                        state <= ctrl_enable ? S_WAIT_TICK : S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            4'h0: rd_mux = {30'd0, ctrl_irq_en, ctrl_enable};
            4'h4: rd_mux = 32'(period_q);
            4'hC: rd_mux = {16'd0, level_byte, 2'b00, sticky_late, sticky_und,
                            sticky_ovf, fifo_full, fifo_empty, fsm_busy};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge bus_clock or negedge resetn) begin
        if (!resetn) begin
            reg_rdata <= '0;
        end else if (reg_rd) begin
            reg_rdata <= rd_mux;
        end
    end

endmodule
